temp_display_ctrl: RTL and testbench

Sequencing controller for the temperature display path. Periodically fetches a 13-bit two's-complement temperature sample from the sensor interface over a four-phase req/ack handshake and holds it as `tc` for the `tdisplay` converter. Toggles the Celsius/Fahrenheit select `c_f` from a debounced push-button, and time-multiplexes `tdisplay`'s four BCD digits onto a 4-digit seven-segment display.

---
 rtl/tdisplay_pkg.sv | 14 +
 rtl/temp_display_ctrl_if.sv | 11 +
 rtl/temp_display_ctrl_btn_debounce.sv | 38 +++
 rtl/temp_display_ctrl.sv | 133 +++++++++++++
 tb/tb_temp_display_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdisplay_pkg.sv
// Shared types and widths for the temperature display path (controller and tdisplay).
package tdisplay_pkg;
    localparam int TC_W  = 13;
    localparam int BCD_W = 4;
    localparam int NDIG  = 4;
    localparam int IDX_W = $clog2(NDIG);

    typedef enum logic [1:0] {WAIT, REQ, RELEASE} smp_state_t;

    // Active-low one-hot digit enable for a scan position.
    function automatic logic [NDIG-1:0] an_decode(input logic [IDX_W-1:0] idx);
        return ~(NDIG'(1) << idx);
    endfunction
endpackage

// File: rtl/temp_display_ctrl_if.sv
// Four-phase sample handshake between the display controller and the sensor interface.
interface temp_display_ctrl_if;
    import tdisplay_pkg::*;

    logic            smp_req;
    logic            smp_ack;
    logic [TC_W-1:0] smp_data;

    modport master (output smp_req, input smp_ack, input smp_data);
    modport slave  (input smp_req, output smp_ack, output smp_data);
endinterface

// File: rtl/temp_display_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stability counter, one-cycle pulse on accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    // The new level is taken on the same edge the count completes, so the pulse is combinational.
    assign accept = (sync_reg[1] != stable_reg) && (cnt_reg == CW'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept && sync_reg[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                stable_reg <= sync_reg[1];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end
endmodule

// File: rtl/temp_display_ctrl.sv
// Temperature display sequencer: periodic sample fetch, C/F toggle, 4-digit scan.
// Optional leading-zero blanking is enabled by defining TDC_LZ_BLANK_EN.
module temp_display_ctrl
    import tdisplay_pkg::*;
#(
    parameter int SAMPLE_PERIOD   = 1_000_000,
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 unit_btn,
    temp_display_ctrl_if.master  smp,
    output logic [TC_W-1:0]      tc,
    output logic                 c_f,
    input  logic [BCD_W-1:0]     thousands,
    input  logic [BCD_W-1:0]     hundreds,
    input  logic [BCD_W-1:0]     tens,
    input  logic [BCD_W-1:0]     ones,
    input  logic                 sign,
    output logic [NDIG-1:0]      an,
    output logic [BCD_W-1:0]     digit,
    output logic                 digit_blank,
    output logic                 neg
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    smp_state_t      state_reg, state_next;
    logic [PW-1:0]   smp_cnt_reg, smp_cnt_next;
    logic [TC_W-1:0] tc_reg, tc_next;
    logic            c_f_reg;
    logic            btn_rise;
    logic [SW-1:0]   scan_cnt_reg;
    logic [IDX_W-1:0] idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= WAIT;
            smp_cnt_reg <= '0;
            tc_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            smp_cnt_reg <= smp_cnt_next;
            tc_reg      <= tc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        smp_cnt_next = smp_cnt_reg;
        tc_next      = tc_reg;
        case (state_reg)
            WAIT: begin
                if (smp_cnt_reg == PW'(SAMPLE_PERIOD - 1)) begin
                    state_next   = REQ;
                    smp_cnt_next = '0;
                end else begin
                    smp_cnt_next = smp_cnt_reg + PW'(1);
                end
            end
            REQ: begin
                if (smp.smp_ack) begin
                    tc_next    = smp.smp_data;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!smp.smp_ack) state_next = WAIT;
            end
            default: state_next = WAIT;
        endcase
    end

    // Decoded from the state register so reset drops the request without waiting for a clock.
    assign smp.smp_req = (state_reg == REQ);
    assign tc          = tc_reg;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (unit_btn),
        .rise (btn_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           c_f_reg <= 1'b0;
        else if (btn_rise) c_f_reg <= ~c_f_reg;
    end
    assign c_f = c_f_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + IDX_W'(1);
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SW'(1);
        end
    end

    logic [BCD_W-1:0] bcd      [NDIG];
    logic             lz_blank [NDIG];

    assign bcd[0] = ones;
    assign bcd[1] = tens;
    assign bcd[2] = hundreds;
    assign bcd[3] = thousands;

    // A position is a leading zero when it and every higher position are zero.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
        if (gi < 2) begin : g_never
            assign lz_blank[gi] = 1'b0;
        end else if (gi == NDIG - 1) begin : g_top
            assign lz_blank[gi] = (bcd[gi] == '0);
        end else begin : g_mid
            assign lz_blank[gi] = (bcd[gi] == '0) && lz_blank[gi+1];
        end
    end

    assign an    = an_decode(idx_reg);
    assign digit = bcd[idx_reg];
    assign neg   = sign;
`ifdef TDC_LZ_BLANK_EN
    assign digit_blank = lz_blank[idx_reg];
`else
    assign digit_blank = 1'b0;
`endif
endmodule

// File: tb/tb_temp_display_ctrl.sv
// Self-checking bench for temp_display_ctrl: handshake scoreboard, button sequences, scan table.
module tb_temp_display_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        unit_btn;
    logic [12:0] tc;
    logic        c_f;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic        sign;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        digit_blank;
    logic        neg;

    temp_display_ctrl_if smp_if();

    temp_display_ctrl #(
        .SAMPLE_PERIOD   (8),
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .unit_btn    (unit_btn),
        .smp         (smp_if),
        .tc          (tc),
        .c_f         (c_f),
        .thousands   (thousands),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .sign        (sign),
        .an          (an),
        .digit       (digit),
        .digit_blank (digit_blank),
        .neg         (neg)
    );

    always #5 clk = ~clk;

`ifdef TDC_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] sb_q[$];
    logic        exp_cf;

    typedef struct packed {
        logic [3:0]      th, hu, te, on;
        logic            sg;
        logic [3:0][3:0] dig;
        logic [3:0]      blk;
    } scan_vec_t;
    scan_vec_t vecs[5];

    logic [12:0] hs_data[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_req(output int j);
        j = 0;
        while (!smp_if.smp_req && j < 40) begin
            @(negedge clk);
            j++;
        end
    endtask

    // Handshake with the request already up: ack with data, hold 5 cycles, drop, time the next request.
    task automatic do_handshake(input logic [12:0] d);
        logic [12:0] e;
        int j;
        smp_if.smp_data = d;
        smp_if.smp_ack  = 1'b1;
        sb_q.push_back(d);
        @(negedge clk);
        check("req_fall", {31'd0, smp_if.smp_req}, 32'd0);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("tc_load", {19'd0, tc}, {19'd0, e});
            $display("[TB] sample %04h -> tc %04h", d, tc);
        end
        smp_if.smp_data = ~d;
        repeat (4) @(negedge clk);
        check("tc_hold", {19'd0, tc}, {19'd0, d});
        check("req_low_ack", {31'd0, smp_if.smp_req}, 32'd0);
        smp_if.smp_ack = 1'b0;
        wait_req(j);
        check("req_after_drop", j, 9);
    endtask

    task automatic clean_press();
        int j;
        logic last;
        last = c_f;
        unit_btn = 1'b1;
        j = 0;
        while (c_f == last && j < 20) begin
            @(negedge clk);
            j++;
        end
        exp_cf = ~exp_cf;
        check("press_latency", j, 5);
        check("press_cf", {31'd0, c_f}, {31'd0, exp_cf});
        repeat (3) @(negedge clk);
        unit_btn = 1'b0;
        repeat (8) @(negedge clk);
        check("release_cf", {31'd0, c_f}, {31'd0, exp_cf});
        $display("[TB] button press -> c_f %0b", c_f);
    endtask

    initial begin
        int j, toggles, idx;
        logic last;
        logic [3:0] one_hot;
        logic [8:0] bseq;

        rst = 1'b1; unit_btn = 1'b0;
        smp_if.smp_ack = 1'b0; smp_if.smp_data = '0;
        thousands = '0; hundreds = '0; tens = '0; ones = '0; sign = 1'b0;
        exp_cf = 1'b0;
        hs_data[0] = 13'h0190; hs_data[1] = 13'h1F00; hs_data[2] = 13'h0000;
        hs_data[3] = 13'h0FFF; hs_data[4] = 13'h1000;
        vecs[0] = '{4'd0, 4'd0, 4'd2, 4'd5, 1'b1, {4'd0, 4'd0, 4'd2, 4'd5}, 4'b1100};
        vecs[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, {4'd1, 4'd2, 4'd3, 4'd4}, 4'b0000};
        vecs[2] = '{4'd0, 4'd7, 4'd0, 4'd0, 1'b1, {4'd0, 4'd7, 4'd0, 4'd0}, 4'b1000};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, {4'd0, 4'd0, 4'd0, 4'd0}, 4'b1100};
        vecs[4] = '{4'd9, 4'd0, 4'd0, 4'd3, 1'b0, {4'd9, 4'd0, 4'd0, 4'd3}, 4'b0000};

        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, smp_if.smp_req}, 32'd0);
        check("rst_tc", {19'd0, tc}, 32'd0);
        check("rst_cf", {31'd0, c_f}, 32'd0);
        check("rst_an", {28'd0, an}, 32'h0000000E);

        rst = 1'b0;
        wait_req(j);
        check("first_req", j, 8);
        check("idle_tc", {19'd0, tc}, 32'd0);
        check("idle_cf", {31'd0, c_f}, 32'd0);

        for (int i = 0; i < 5; i++) do_handshake(hs_data[i]);

        // Bounce 1,0,1 then hold: exactly one toggle, none on release.
        bseq = 9'b1_1111_1101;
        toggles = 0;
        last = c_f;
        for (int i = 0; i < 13; i++) begin
            unit_btn = (i < 9) ? bseq[i] : 1'b1;
            @(negedge clk);
            if (c_f != last) toggles++;
            last = c_f;
        end
        unit_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c_f != last) toggles++;
            last = c_f;
        end
        exp_cf = ~exp_cf;
        check("bounce_toggles", toggles, 1);
        check("bounce_cf", {31'd0, c_f}, {31'd0, exp_cf});
        $display("[TB] bounce sequence -> c_f %0b", c_f);

        // Request is still pending with no ack; presses must not disturb it.
        clean_press();
        check("req_held", {31'd0, smp_if.smp_req}, 32'd1);
        do_handshake(13'h0A5A);
        clean_press();
        check("req_held2", {31'd0, smp_if.smp_req}, 32'd1);
        check("pre_rst_tc", {19'd0, tc}, 32'h0A5A);

        rst = 1'b1;
        #1;
        check("async_req", {31'd0, smp_if.smp_req}, 32'd0);
        check("async_tc", {19'd0, tc}, 32'd0);
        check("async_cf", {31'd0, c_f}, 32'd0);
        exp_cf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_req(j);
        check("req_after_rst", j, 8);
        $display("[TB] reset mid-handshake -> next req after %0d cycles", j);

        for (int v = 0; v < 5; v++) begin
            thousands = vecs[v].th; hundreds = vecs[v].hu;
            tens = vecs[v].te; ones = vecs[v].on; sign = vecs[v].sg;
            j = 0;
            while (an != 4'b0111 && j < 40) begin @(negedge clk); j++; end
            while (an == 4'b0111 && j < 40) begin @(negedge clk); j++; end
            check("scan_align", {31'd0, j < 40}, 32'd1);
            check("scan_neg", {31'd0, neg}, {31'd0, vecs[v].sg});
            for (int k = 0; k < 16; k++) begin
                idx = k / 4;
                one_hot = 4'b0001;
                check("scan_an", {28'd0, an}, {28'd0, ~(one_hot << idx)});
                check("scan_digit", {28'd0, digit}, {28'd0, vecs[v].dig[idx]});
                check("scan_blank", {31'd0, digit_blank}, {31'd0, LZ_EN & vecs[v].blk[idx]});
                @(negedge clk);
            end
            $display("[TB] scan vector %0d (%0d%0d%0d%0d sign %0b) checked", v,
                     vecs[v].th, vecs[v].hu, vecs[v].te, vecs[v].on, vecs[v].sg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
